// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: phase encoding,
// lamp codes and the phase-timer width.
package traffic_pkg;

    localparam int unsigned CNT_W = 16;

    // Phase codes; values 5..7 are unused and recover to MAIN_GREEN.
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        WALK        = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4
    } state_e;

    // Lamp bundles are {R,Y,G}, one-hot.
    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

endpackage

// File: rtl/traffic_fsm_phase_timer.sv
// Loadable down-counter timing each phase. Holds at zero until reloaded.
module phase_timer
    import traffic_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register; reset value is the first phase's duration minus one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_fsm.sv
// Traffic intersection controller: main/side road lamps, optional
// pedestrian walk phase and a one-shot green extension on side-road demand.
module traffic_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned T_BASE = 6,
    parameter int unsigned T_EXT  = 3,
    parameter int unsigned T_YEL  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pendingWalk,
    input  logic       sensor,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_lamp,
    output logic       reset_by_fsm,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] BASE_M1 = CNT_W'(T_BASE - 1);
    localparam logic [CNT_W-1:0] EXT_M1  = CNT_W'(T_EXT - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(T_YEL - 1);

    state_e           state_q, state_d;
    logic             ext_q, ext_d;
    logic             rbf_q, rbf_d;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             timer_zero;

    phase_timer #(
        .RST_VAL (BASE_M1)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load     (load),
        .load_val (load_val),
        .zero     (timer_zero)
    );

    // Next-state, timer reload and extension flag; exits happen when the timer is at zero.
    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            MAIN_GREEN, SIDE_GREEN: begin
                if (timer_zero) begin
                    load = 1'b1;
                    if (sensor && !ext_q) begin
                        load_val = EXT_M1;
                        ext_d    = 1'b1;
                    end else begin
                        load_val = YEL_M1;
                        ext_d    = 1'b0;
                        state_d  = (state_q == MAIN_GREEN) ? MAIN_YELLOW : SIDE_YELLOW;
                    end
                end
            end
            MAIN_YELLOW: begin
                if (timer_zero) begin
                    load = 1'b1;
                    if (pendingWalk) begin
                        state_d  = WALK;
                        load_val = EXT_M1;
                    end else begin
                        state_d  = SIDE_GREEN;
                        load_val = BASE_M1;
                    end
                end
            end
            WALK: begin
                if (timer_zero) begin
                    load     = 1'b1;
                    load_val = BASE_M1;
                    state_d  = SIDE_GREEN;
                end
            end
            SIDE_YELLOW: begin
                if (timer_zero) begin
                    load     = 1'b1;
                    load_val = BASE_M1;
                    state_d  = MAIN_GREEN;
                end
            end
            default: begin
                load     = 1'b1;
                load_val = BASE_M1;
                ext_d    = 1'b0;
                state_d  = MAIN_GREEN;
            end
        endcase
        // Clear pulse registered so it is high exactly in the first WALK cycle.
        rbf_d = (state_d == WALK) && (state_q != WALK);
    end

    // State, extension flag and walk-clear pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MAIN_GREEN;
            ext_q   <= 1'b0;
            rbf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
            rbf_q   <= rbf_d;
        end
    end

    // Moore lamp decode; unknown codes show all-red for their single cycle.
    always_comb begin
        main_light = LAMP_R;
        side_light = LAMP_R;
        walk_lamp  = 1'b0;
        case (state_q)
            MAIN_GREEN:  main_light = LAMP_G;
            MAIN_YELLOW: main_light = LAMP_Y;
            WALK:        walk_lamp  = 1'b1;
            SIDE_GREEN:  side_light = LAMP_G;
            SIDE_YELLOW: side_light = LAMP_Y;
            default: ;
        endcase
    end

    assign reset_by_fsm = rbf_q;
    assign phase        = state_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Directed scoreboard bench for traffic_fsm: expected per-cycle outputs are
// queued as phase segments and popped once per clock.
module tb_traffic_fsm;
    import traffic_pkg::*;

    localparam logic [2:0] PH_MG = MAIN_GREEN;
    localparam logic [2:0] PH_MY = MAIN_YELLOW;
    localparam logic [2:0] PH_W  = WALK;
    localparam logic [2:0] PH_SG = SIDE_GREEN;
    localparam logic [2:0] PH_SY = SIDE_YELLOW;

    typedef struct packed {
        logic [2:0] ph;
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        logic       r;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       pendingWalk;
    logic       sensor;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;
    logic       reset_by_fsm;
    logic [2:0] phase;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    traffic_fsm #(
        .T_BASE (6),
        .T_EXT  (3),
        .T_YEL  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pendingWalk  (pendingWalk),
        .sensor       (sensor),
        .main_light   (main_light),
        .side_light   (side_light),
        .walk_lamp    (walk_lamp),
        .reset_by_fsm (reset_by_fsm),
        .phase        (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic onehot3(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    task automatic push_seg(input logic [2:0] ph, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ph = ph;
            e.w  = 1'b0;
            e.r  = 1'b0;
            case (ph)
                PH_MG:   begin e.m = 3'b001; e.s = 3'b100; end
                PH_MY:   begin e.m = 3'b010; e.s = 3'b100; end
                PH_W:    begin e.m = 3'b100; e.s = 3'b100; e.w = 1'b1; e.r = (i == 0); end
                PH_SG:   begin e.m = 3'b100; e.s = 3'b001; end
                default: begin e.m = 3'b100; e.s = 3'b010; end
            endcase
            sb.push_back(e);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard: observed output with no expectation queued at %0t", $time);
            return;
        end
        e = sb.pop_front();
        n_assert++;
        assert (phase === e.ph) else begin
            n_fail++;
            $error("FAIL phase: observed %0d expected %0d at %0t", phase, e.ph, $time);
        end
        n_assert++;
        assert (main_light === e.m) else begin
            n_fail++;
            $error("FAIL main_light: observed %b expected %b at %0t", main_light, e.m, $time);
        end
        n_assert++;
        assert (side_light === e.s) else begin
            n_fail++;
            $error("FAIL side_light: observed %b expected %b at %0t", side_light, e.s, $time);
        end
        n_assert++;
        assert (walk_lamp === e.w) else begin
            n_fail++;
            $error("FAIL walk_lamp: observed %b expected %b at %0t", walk_lamp, e.w, $time);
        end
        n_assert++;
        assert (reset_by_fsm === e.r) else begin
            n_fail++;
            $error("FAIL reset_by_fsm: observed %b expected %b at %0t", reset_by_fsm, e.r, $time);
        end
        n_assert++;
        assert (onehot3(main_light) && onehot3(side_light) &&
                (main_light == 3'b100 || side_light == 3'b100)) else begin
            n_fail++;
            $error("FAIL lamp_safety: observed main=%b side=%b expected one-hot with a red road at %0t",
                   main_light, side_light, $time);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_cycle();
        end
    endtask

    // Asserts reset mid-cycle (checked before any edge), holds one edge, releases mid-cycle.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        push_seg(PH_MG, 1);
        check_cycle();
        @(posedge clk);
        #1;
        push_seg(PH_MG, 1);
        check_cycle();
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        pendingWalk = 1'b0;
        sensor      = 1'b0;
        @(posedge clk);
        #1;

        // Idle loop, period 16.
        do_reset();
        push_seg(PH_MG, 6); push_seg(PH_MY, 2); push_seg(PH_SG, 6);
        push_seg(PH_SY, 2); push_seg(PH_MG, 6);
        check_cycle();
        run_cycles(21);

        // Walk request from cycle 3; second push during WALK served next pass.
        do_reset();
        push_seg(PH_MG, 6); push_seg(PH_MY, 2); push_seg(PH_W, 3);
        push_seg(PH_SG, 6); push_seg(PH_SY, 2); push_seg(PH_MG, 6);
        push_seg(PH_MY, 2); push_seg(PH_W, 1);
        check_cycle();
        run_cycles(2);
        pendingWalk = 1'b1;
        run_cycles(5);
        run_cycles(1);
        pendingWalk = 1'b0;
        run_cycles(1);
        pendingWalk = 1'b1;
        run_cycles(1);
        run_cycles(16);
        run_cycles(1);
        pendingWalk = 1'b0;

        // Constant sensor: each green extended once to 9 cycles, period 22.
        sensor = 1'b1;
        do_reset();
        push_seg(PH_MG, 9); push_seg(PH_MY, 2); push_seg(PH_SG, 9);
        push_seg(PH_SY, 2); push_seg(PH_MG, 9); push_seg(PH_MY, 1);
        check_cycle();
        run_cycles(31);
        sensor = 1'b0;

        // Request present at the MAIN_YELLOW exit edge: WALK taken.
        do_reset();
        push_seg(PH_MG, 6); push_seg(PH_MY, 2); push_seg(PH_W, 3); push_seg(PH_SG, 1);
        check_cycle();
        run_cycles(5);
        run_cycles(2);
        pendingWalk = 1'b1;
        run_cycles(1);
        pendingWalk = 1'b0;
        run_cycles(3);

        // Request one cycle after the exit edge: deferred to the next pass.
        do_reset();
        push_seg(PH_MG, 6); push_seg(PH_MY, 2); push_seg(PH_SG, 6);
        push_seg(PH_SY, 2); push_seg(PH_MG, 6); push_seg(PH_MY, 2); push_seg(PH_W, 1);
        check_cycle();
        run_cycles(7);
        run_cycles(1);
        pendingWalk = 1'b1;
        run_cycles(15);
        run_cycles(1);
        pendingWalk = 1'b0;

        // Reset during WALK cycle 2, then full MAIN_GREEN after release.
        do_reset();
        push_seg(PH_MG, 6); push_seg(PH_MY, 2); push_seg(PH_W, 2);
        check_cycle();
        run_cycles(2);
        pendingWalk = 1'b1;
        run_cycles(5);
        run_cycles(2);
        pendingWalk = 1'b0;
        do_reset();
        push_seg(PH_MG, 6); push_seg(PH_MY, 2); push_seg(PH_SG, 1);
        check_cycle();
        run_cycles(8);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d entries left expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_fsm.md
TRAFFIC_FSM -- requirements
Module: traffic_fsm

Interface
REQ-001 The block SHALL have parameter T_BASE, default 6: base green duration in clock cycles, minimum 1.
REQ-002 The block SHALL have parameter T_EXT, default 3: green-extension and walk duration in clock cycles, minimum 1.
REQ-003 The block SHALL have parameter T_YEL, default 2: yellow duration in clock cycles, minimum 1.
REQ-004 The block SHALL have port clk  input  1  rising-edge system clock.
REQ-005 The block SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port pendingWalk  input  1  latched pedestrian request from the walk register.
REQ-007 The block SHALL have port sensor  input  1  side-road vehicle present, synchronous to clk.
REQ-008 The block SHALL have port main_light  output  3  main-road lamps {R,Y,G}, one-hot.
REQ-009 The block SHALL have port side_light  output  3  side-road lamps {R,Y,G}, one-hot.
REQ-010 The block SHALL have port walk_lamp  output  1  pedestrian walk indicator.
REQ-011 The block SHALL have port reset_by_fsm  output  1  one-cycle clear pulse to the walk register.
REQ-012 The block SHALL have port phase  output  3  current state code, for debug.

Function
REQ-013 The state set SHALL be: MAIN_GREEN, MAIN_YELLOW, WALK, SIDE_GREEN, SIDE_YELLOW.
REQ-014 A down-counter SHALL load duration-1 on state entry; the state SHALL be exited on the clock edge where the counter equals 0, so each state lasts exactly its duration.
REQ-015 MAIN_GREEN and SIDE_GREEN SHALL last T_BASE cycles.
REQ-016 Extension: if counter==0 in a green state, sensor==1 and the extension flag is clear, the block SHALL reload T_EXT-1, set the flag and stay in the state.
REQ-017 The extension SHALL happen at most once per green visit; the flag SHALL clear on leaving the state.
REQ-018 MAIN_YELLOW and SIDE_YELLOW SHALL last T_YEL cycles; WALK SHALL last T_EXT cycles.
REQ-019 The transition sequence SHALL be: MAIN_GREEN -> MAIN_YELLOW.
REQ-020 From MAIN_YELLOW the block SHALL go to WALK if pendingWalk==1 on the exit edge, otherwise to SIDE_GREEN.
REQ-021 The remaining transitions SHALL be WALK -> SIDE_GREEN -> SIDE_YELLOW -> MAIN_GREEN.
REQ-022 pendingWalk SHALL be sampled only on the MAIN_YELLOW exit edge and ignored in all other states.
REQ-023 Lamp outputs SHALL be Moore, decoded from state only, with R=100, Y=010, G=001.
REQ-024 MAIN_GREEN SHALL drive main=G, side=R.
REQ-025 MAIN_YELLOW SHALL drive main=Y, side=R.
REQ-026 WALK SHALL drive main=R, side=R, walk_lamp=1.
REQ-027 SIDE_GREEN SHALL drive main=R, side=G; SIDE_YELLOW SHALL drive main=R, side=Y.
REQ-028 walk_lamp SHALL be 0 in every state except WALK.
REQ-029 Never both roads non-red SHALL hold in any cycle, including the first cycle after reset release.
REQ-030 reset_by_fsm SHALL be registered and high only during the first cycle of WALK, so the walk register clears on the next edge.
REQ-031 A walk push arriving during WALK, after the clear, SHALL remain pending and be served on the next cycle of the sequence.
REQ-032 The counter SHALL be 16 bits; durations above 65536 are illegal.
REQ-033 Undefined phase codes SHALL return to MAIN_GREEN on the next edge.

Reset
REQ-034 While reset==0 the block SHALL hold: state=MAIN_GREEN, counter=T_BASE-1, extension flag=0, main_light=001, side_light=100, walk_lamp=0, reset_by_fsm=0.
REQ-035 Reset asserted mid-phase, including mid-WALK or mid-extension, SHALL take effect immediately without waiting for a clock edge.
REQ-036 After reset release, MAIN_GREEN SHALL last a full T_BASE cycles.

Structure
REQ-037 Package traffic_pkg SHALL hold the state encoding, the lamp codes (LAMP_R, LAMP_Y, LAMP_G) and the counter width constant.
REQ-038 Sub-module phase_timer SHALL be a loadable 16-bit down-counter with load, load-value and zero outputs, instantiated once.
REQ-039 The FSM and output decode SHALL live in traffic_fsm.

Verification
REQ-040 Idle loop (defaults, sensor=0, pendingWalk=0) -> MAIN_GREEN 6, MAIN_YELLOW 2, SIDE_GREEN 6, SIDE_YELLOW 2 cycles; period 16; walk_lamp never high.
REQ-041 pendingWalk=1 held from cycle 3 -> WALK entered after MAIN_YELLOW for 3 cycles, reset_by_fsm high exactly in WALK cycle 1, period 19.
REQ-042 sensor=1 constantly -> each green lasts 9 cycles, not 12; period 22.
REQ-043 pendingWalk rises on the MAIN_YELLOW exit edge -> WALK taken; a rise one cycle after that edge -> WALK deferred to the next pass.
REQ-044 Reset asserted in WALK cycle 2 -> outputs go to MAIN_GREEN values asynchronously, reset_by_fsm=0; after release, MAIN_GREEN lasts 6 cycles.
REQ-045 Every cycle of every test -> assertion: main_light and side_light are one-hot, and at least one of them equals 100.
